// File: rtl/daq_event_unpacker_if.sv
// Event-stream input and per-readout payload output bundle
// for the DAQ event unpacker.
interface daq_event_unpacker_if;
    logic [63:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [63:0] m_data;
    logic [1:0]  m_keep;
    logic [3:0]  m_idx;
    logic        m_first;
    logic        m_last;
    logic        m_valid;
    logic        m_ready;

    modport slave (
        input  s_data, s_valid, m_ready,
        output s_ready, m_data, m_keep, m_idx,
        output m_first, m_last, m_valid
    );

    modport master (
        output s_data, s_valid, m_ready,
        input  s_ready, m_data, m_keep, m_idx,
        input  m_first, m_last, m_valid
    );
endinterface

// File: rtl/daq_event_unpacker.sv
// Validates DAQ event headers and splits the bundled payload
// into per-readout 64-bit beats tagged with index/first/last.
module daq_event_unpacker #(
    parameter logic [3:0] FORMAT_VERSION = 4'h1,
    parameter bit         CHECK_FPGA_ID  = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  expected_fpga_id,
    daq_event_unpacker_if.slave bus,
    output logic [7:0]  evt_fpga_id,
    output logic [3:0]  evt_nreadouts,
    output logic        evt_done,
    output logic        err_magic,
    output logic        err_version,
    output logic        err_length,
    output logic [15:0] evt_count,
    output logic [15:0] err_count
);

    localparam logic [31:0] MAGIC = 32'hbeef2021;

    typedef enum logic [2:0] {
        ST_HDR0,
        ST_HDR_LEN,
        ST_CHECK,
        ST_DATA,
        ST_DISCARD,
        ST_HUNT
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_alive;
    logic [3:0]  r_ver;
    logic [7:0]  r_fid;
    logic [3:0]  r_n;
    logic [15:0] r_tot;
    logic [1:0]  r_wcnt;
    logic [16:0] r_sum;
    logic [9:0]  r_len [16];
    logic [15:0] r_rem;
    logic [3:0]  r_idx;
    logic [9:0]  r_bcnt;

    logic [63:0] r_m_data;
    logic [1:0]  r_m_keep;
    logic [3:0]  r_m_idx;
    logic        r_m_first;
    logic        r_m_last;
    logic        r_m_valid;

    logic        r_evt_done;
    logic        r_err_magic;
    logic        r_err_version;
    logic        r_err_length;
    logic [7:0]  r_evt_fid;
    logic [3:0]  r_evt_n;
    logic [15:0] r_evt_count;
    logic [15:0] r_err_count;

    logic        w_s_ready;
    logic        w_beat;
    logic        w_magic_ok;
    logic        w_hdr0_take;
    logic        w_len_take;
    logic        w_data_take;
    logic        w_disc_take;
    logic        w_err_magic;
    logic        w_err_ver;
    logic        w_err_len;
    logic        w_ok;
    logic        w_done;
    logic        w_bad_ver;
    logic        w_bad_n;
    logic        w_bad_sum;
    logic [16:0] w_lane_sum;
    logic [4:0]  w_start;
    logic        w_nxt_found;
    logic [3:0]  w_nxt_idx;
    logic [9:0]  w_cur_w;
    logic        w_cur_last;

    function automatic logic [9:0] f_words(input logic [9:0] len);
        return {1'b0, len[9:1]} + {9'd0, len[0]};
    endfunction

    assign w_beat     = bus.s_valid && w_s_ready;
    assign w_magic_ok = (bus.s_data[31:0] == MAGIC);
    assign w_cur_w    = f_words(r_len[r_idx]);
    assign w_cur_last = (r_bcnt == w_cur_w - 10'd1);

    assign w_bad_ver = (r_ver != FORMAT_VERSION) ||
                       (CHECK_FPGA_ID && (r_fid != expected_fpga_id));
    assign w_bad_n   = (r_n == 4'd0);
    assign w_bad_sum = (r_sum != {1'b0, r_tot});

    // Words contributed by the four length lanes of this header word.
    always_comb begin
        w_lane_sum = 17'd0;
        for (int j = 0; j < 4; j++) begin
            if ({r_wcnt, 2'(j)} < r_n) begin
                w_lane_sum = w_lane_sum +
                    17'(f_words(bus.s_data[16*j +: 10]));
            end
        end
    end

    // Lowest non-empty readout at or above the search start.
    always_comb begin
        w_start     = (r_state == ST_CHECK) ? 5'd0 : {1'b0, r_idx} + 5'd1;
        w_nxt_found = 1'b0;
        w_nxt_idx   = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if ((5'(i) >= w_start) && (4'(i) < r_n) &&
                (f_words(r_len[i]) != 10'd0)) begin
                w_nxt_found = 1'b1;
                w_nxt_idx   = 4'(i);
            end
        end
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_s_ready   = 1'b0;
        w_hdr0_take = 1'b0;
        w_len_take  = 1'b0;
        w_data_take = 1'b0;
        w_disc_take = 1'b0;
        w_err_magic = 1'b0;
        w_err_ver   = 1'b0;
        w_err_len   = 1'b0;
        w_ok        = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            ST_HDR0: begin
                w_s_ready = r_alive;
                if (r_alive && bus.s_valid) begin
                    if (w_magic_ok) begin
                        w_hdr0_take = 1'b1;
                        w_state_nxt = ST_HDR_LEN;
                    end else begin
                        w_err_magic = 1'b1;
                        w_state_nxt = ST_HUNT;
                    end
                end
            end
            ST_HUNT: begin
                w_s_ready = 1'b1;
                if (bus.s_valid && w_magic_ok) begin
                    w_hdr0_take = 1'b1;
                    w_state_nxt = ST_HDR_LEN;
                end
            end
            ST_HDR_LEN: begin
                w_s_ready = 1'b1;
                if (bus.s_valid) begin
                    w_len_take = 1'b1;
                    if (r_wcnt == 2'd3) begin
                        w_state_nxt = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (w_bad_ver) begin
                    w_err_ver = 1'b1;
                end else if (w_bad_n || w_bad_sum) begin
                    w_err_len = 1'b1;
                end
                if (w_bad_ver || w_bad_n || w_bad_sum) begin
                    w_state_nxt = (r_tot <= 16'd5) ? ST_HDR0 : ST_DISCARD;
                end else begin
                    w_ok = 1'b1;
                    if (r_sum == 17'd5) begin
                        w_done      = 1'b1;
                        w_state_nxt = ST_HDR0;
                    end else begin
                        w_state_nxt = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                w_s_ready = !r_m_valid || bus.m_ready;
                if (w_beat) begin
                    w_data_take = 1'b1;
                    if (w_cur_last && !w_nxt_found) begin
                        w_done      = 1'b1;
                        w_state_nxt = ST_HDR0;
                    end
                end
            end
            ST_DISCARD: begin
                w_s_ready = 1'b1;
                if (r_rem == 16'd0) begin
                    w_state_nxt = ST_HDR0;
                end else if (bus.s_valid) begin
                    w_disc_take = 1'b1;
                    if (r_rem == 16'd1) begin
                        w_state_nxt = ST_HDR0;
                    end
                end
            end
            default: w_state_nxt = ST_HDR0;
        endcase
    end

    // State register; r_alive holds s_ready low until the first clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_HDR0;
            r_alive <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_alive <= 1'b1;
        end
    end

    // Header capture, length RAM and running word-count sum.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ver  <= '0;
            r_fid  <= '0;
            r_n    <= '0;
            r_tot  <= '0;
            r_wcnt <= '0;
            r_sum  <= '0;
            for (int i = 0; i < 16; i++) begin
                r_len[i] <= '0;
            end
        end else if (w_hdr0_take) begin
            r_ver  <= bus.s_data[63:60];
            r_fid  <= bus.s_data[59:52];
            r_n    <= bus.s_data[51:48];
            r_tot  <= bus.s_data[47:32];
            r_wcnt <= 2'd0;
            r_sum  <= 17'd5;
        end else if (w_len_take) begin
            for (int j = 0; j < 4; j++) begin
                r_len[{r_wcnt, 2'(j)}] <= bus.s_data[16*j +: 10];
            end
            r_sum  <= r_sum + w_lane_sum;
            r_wcnt <= r_wcnt + 2'd1;
        end
    end

    // Payload walk: current readout, beat counter and discard budget.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx  <= '0;
            r_bcnt <= '0;
            r_rem  <= '0;
        end else begin
            if (r_state == ST_CHECK) begin
                r_rem  <= r_tot - 16'd5;
                r_idx  <= w_nxt_idx;
                r_bcnt <= 10'd0;
            end else if (w_data_take) begin
                if (w_cur_last) begin
                    r_idx  <= w_nxt_idx;
                    r_bcnt <= 10'd0;
                end else begin
                    r_bcnt <= r_bcnt + 10'd1;
                end
            end else if (w_disc_take) begin
                r_rem <= r_rem - 16'd1;
            end
        end
    end

    // Registered output stage, held stable until m_ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_m_data  <= '0;
            r_m_keep  <= '0;
            r_m_idx   <= '0;
            r_m_first <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_valid <= 1'b0;
        end else if (w_data_take) begin
            r_m_data  <= bus.s_data;
            r_m_idx   <= r_idx;
            r_m_first <= (r_bcnt == 10'd0);
            r_m_last  <= w_cur_last;
            r_m_keep  <= (w_cur_last && r_len[r_idx][0]) ? 2'b01 : 2'b11;
            r_m_valid <= 1'b1;
        end else if (bus.m_ready) begin
            r_m_valid <= 1'b0;
        end
    end

    // Status pulses, last-event info and event/error counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_evt_done    <= 1'b0;
            r_err_magic   <= 1'b0;
            r_err_version <= 1'b0;
            r_err_length  <= 1'b0;
            r_evt_fid     <= '0;
            r_evt_n       <= '0;
            r_evt_count   <= '0;
            r_err_count   <= '0;
        end else begin
            r_evt_done    <= w_done;
            r_err_magic   <= w_err_magic;
            r_err_version <= w_err_ver;
            r_err_length  <= w_err_len;
            if (w_ok) begin
                r_evt_fid <= r_fid;
                r_evt_n   <= r_n;
            end
            if (w_done) begin
                r_evt_count <= r_evt_count + 16'd1;
            end
            if ((w_err_magic || w_err_ver || w_err_len) &&
                (r_err_count != 16'hFFFF)) begin
                r_err_count <= r_err_count + 16'd1;
            end
        end
    end

    assign bus.s_ready   = w_s_ready;
    assign bus.m_data    = r_m_data;
    assign bus.m_keep    = r_m_keep;
    assign bus.m_idx     = r_m_idx;
    assign bus.m_first   = r_m_first;
    assign bus.m_last    = r_m_last;
    assign bus.m_valid   = r_m_valid;
    assign evt_fpga_id   = r_evt_fid;
    assign evt_nreadouts = r_evt_n;
    assign evt_done      = r_evt_done;
    assign err_magic     = r_err_magic;
    assign err_version   = r_err_version;
    assign err_length    = r_err_length;
    assign evt_count     = r_evt_count;
    assign err_count     = r_err_count;

endmodule

// File: tb/tb_daq_event_unpacker.sv
// Randomised scoreboard bench for the DAQ event unpacker.
// Events are built from the header rules; beats checked by a monitor.
module tb_daq_event_unpacker;

    typedef struct packed {
        logic [63:0] d;
        logic [1:0]  keep;
        logic [3:0]  idx;
        logic        first;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  expected_fpga_id = 8'h00;
    logic [7:0]  evt_fpga_id;
    logic [3:0]  evt_nreadouts;
    logic        evt_done;
    logic        err_magic;
    logic        err_version;
    logic        err_length;
    logic [15:0] evt_count;
    logic [15:0] err_count;

    daq_event_unpacker_if bus();

    daq_event_unpacker dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .expected_fpga_id (expected_fpga_id),
        .bus              (bus),
        .evt_fpga_id      (evt_fpga_id),
        .evt_nreadouts    (evt_nreadouts),
        .evt_done         (evt_done),
        .err_magic        (err_magic),
        .err_version      (err_version),
        .err_length       (err_length),
        .evt_count        (evt_count),
        .err_count        (err_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    logic [63:0] stim_q[$];
    beat_t       exp_q[$];

    int ln[16];
    int exp_done = 0, exp_magic = 0, exp_ver = 0, exp_len = 0;
    int obs_done = 0, obs_magic = 0, obs_ver = 0, obs_len = 0;
    int exp_evt_count = 0, exp_err_count = 0;
    logic [7:0] last_fid = 8'h00;
    logic [3:0] last_n   = 4'h0;

    bit rnd_ready = 1'b0;
    bit rnd_idle  = 1'b0;

    task automatic chk(input string nm, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic chk_beat(input string nm, input beat_t act, input beat_t req);
        n_checks++;
        if (act !== req) begin
            n_errs++;
            $display("FAIL %s: got d=%h k=%b i=%0d f=%b l=%b expected d=%h k=%b i=%0d f=%b l=%b",
                     nm, act.d, act.keep, act.idx, act.first, act.last,
                     req.d, req.keep, req.idx, req.first, req.last);
        end
    endtask

    task automatic fail_now(input string nm);
        n_checks++;
        n_errs++;
        $display("FAIL %s: bound expired", nm);
    endtask

    // Build one event from the header rules; queue words and expected beats.
    task automatic add_event(input logic [3:0] ver, input int n, input int t_adj);
        logic [63:0] w[5];
        logic [63:0] tmp;
        logic [15:0] lane;
        logic [7:0]  fid;
        int wsum, t, wi;
        bit ok;
        beat_t b;
        fid = 8'($urandom);
        wsum = 5;
        for (int i = 0; i < n; i++) wsum += (ln[i] + 1) / 2;
        t = wsum + t_adj;
        if (t < 0) t = 0;
        w[0] = {ver, fid, 4'(n), 16'(t), 32'hbeef2021};
        for (int k = 1; k < 5; k++) w[k] = '0;
        for (int i = 0; i < 16; i++) begin
            lane = {6'($urandom), 10'(ln[i])};
            tmp = w[1 + i / 4];
            tmp[16 * (i % 4) +: 16] = lane;
            w[1 + i / 4] = tmp;
        end
        for (int k = 0; k < 5; k++) stim_q.push_back(w[k]);
        ok = 1'b1;
        if (ver != 4'h1) begin
            ok = 1'b0;
            exp_ver++;
        end else if (n == 0 || t != wsum) begin
            ok = 1'b0;
            exp_len++;
        end
        if (!ok) begin
            exp_err_count++;
            for (int k = 5; k < t; k++) stim_q.push_back({$urandom, $urandom});
        end else begin
            exp_done++;
            exp_evt_count++;
            last_fid = fid;
            last_n = 4'(n);
            for (int i = 0; i < n; i++) begin
                wi = (ln[i] + 1) / 2;
                for (int k = 0; k < wi; k++) begin
                    b.d = {$urandom, $urandom};
                    b.idx = 4'(i);
                    b.first = (k == 0);
                    b.last = (k == wi - 1);
                    b.keep = (b.last && (ln[i] % 2 == 1)) ? 2'b01 : 2'b11;
                    stim_q.push_back(b.d);
                    exp_q.push_back(b);
                end
            end
        end
    endtask

    task automatic set_lens(input int a, input int b, input int c, input int d);
        for (int i = 0; i < 16; i++) ln[i] = $urandom_range(0, 1023);
        ln[0] = a; ln[1] = b; ln[2] = c; ln[3] = d;
    endtask

    task automatic send_words(input int cnt);
        int sent = 0;
        int guard = 0;
        bit acc;
        while (stim_q.size() > 0 && (cnt < 0 || sent < cnt)) begin
            if (rnd_idle && $urandom_range(0, 3) == 0) begin
                bus.s_valid = 1'b0;
                @(posedge clk); #1;
            end else begin
                bus.s_valid = 1'b1;
                bus.s_data = stim_q[0];
                @(negedge clk);
                acc = bus.s_ready;
                @(posedge clk); #1;
                if (acc) begin
                    void'(stim_q.pop_front());
                    sent++;
                end
            end
            guard++;
            if (guard > 20000) begin
                fail_now("send_timeout");
                break;
            end
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int g = 0;
        while ((exp_q.size() > 0 || bus.m_valid) && g < 5000) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 5000) fail_now("drain_timeout");
        repeat (4) begin @(posedge clk); #1; end
    endtask

    task automatic phase_check(input string nm);
        chk({nm, "_done"}, obs_done, exp_done);
        chk({nm, "_magic"}, obs_magic, exp_magic);
        chk({nm, "_ver"}, obs_ver, exp_ver);
        chk({nm, "_len"}, obs_len, exp_len);
        chk({nm, "_evt_count"}, evt_count, exp_evt_count);
        chk({nm, "_err_count"}, err_count, exp_err_count);
        chk({nm, "_fid"}, evt_fpga_id, last_fid);
        chk({nm, "_nro"}, evt_nreadouts, last_n);
    endtask

    task automatic run_phase(input string nm);
        send_words(-1);
        wait_drain();
        phase_check(nm);
    endtask

    // m_ready: always high, or a fresh coin flip each cycle.
    initial begin
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            bus.m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: score accepted beats, check stall stability, count pulses.
    initial begin
        beat_t cur, prev, e;
        bit held;
        held = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                held = 1'b0;
            end else begin
                cur = {bus.m_data, bus.m_keep, bus.m_idx, bus.m_first, bus.m_last};
                if (held) begin
                    chk("stall_valid", bus.m_valid, 1);
                    chk_beat("stall_stable", cur, prev);
                end
                if (bus.m_valid && bus.m_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errs++;
                        $display("FAIL beat_extra: got d=%h i=%0d expected none",
                                 cur.d, cur.idx);
                    end else begin
                        e = exp_q.pop_front();
                        chk_beat("beat", cur, e);
                    end
                end
                held = bus.m_valid && !bus.m_ready;
                prev = cur;
                obs_done  += int'(evt_done);
                obs_magic += int'(err_magic);
                obs_ver   += int'(err_version);
                obs_len   += int'(err_length);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] j;
        int n, v;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", bus.s_ready, 0);
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_counts", {evt_count, err_count}, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("rel_s_ready_low", bus.s_ready, 0);
        @(posedge clk); @(negedge clk);
        chk("rel_s_ready_high", bus.s_ready, 1);
        @(posedge clk); #1;

        // 1: single readout, odd length
        set_lens(3, 0, 0, 0);
        add_event(4'h1, 1, 0);
        run_phase("t1");

        // 2: four readouts incl. an empty one
        set_lens(2, 0, 5, 1);
        add_event(4'h1, 4, 0);
        run_phase("t2");

        // 3: bad magic, junk, then a good event
        stim_q.push_back({32'h12345678, 32'hdeadbeef});
        for (int k = 0; k < 3; k++) begin
            j = {$urandom, $urandom};
            if (j[31:0] == 32'hbeef2021) j[0] = ~j[0];
            stim_q.push_back(j);
        end
        exp_magic++;
        exp_err_count++;
        set_lens(4, 0, 0, 0);
        add_event(4'h1, 1, 0);
        run_phase("t3");

        // 4: total length mismatch then a good event
        set_lens(4, 0, 0, 0);
        add_event(4'h1, 1, 2);
        set_lens(1, 6, 0, 0);
        add_event(4'h1, 2, 0);
        run_phase("t4");

        // 5: test 2 under random back-pressure
        rnd_ready = 1'b1;
        set_lens(2, 0, 5, 1);
        add_event(4'h1, 4, 0);
        run_phase("t5");

        // boundaries: empty payload, N=0 with T<5, bad version
        set_lens(0, 0, 0, 0);
        add_event(4'h1, 2, 0);
        set_lens(0, 0, 0, 0);
        add_event(4'h1, 0, -2);
        set_lens(3, 2, 0, 0);
        add_event(4'h3, 2, 0);
        set_lens(1, 1, 1, 1);
        add_event(4'h1, 4, 0);
        run_phase("bnd");

        // random events, random idles and back-pressure
        rnd_idle = 1'b1;
        for (int e = 0; e < 24; e++) begin
            n = $urandom_range(1, 8);
            for (int i = 0; i < 16; i++)
                ln[i] = (i < n) ? $urandom_range(0, 9) : $urandom_range(0, 1023);
            v = $urandom_range(0, 9);
            if (v == 0) add_event(4'h2, n, 0);
            else if (v == 1) add_event(4'h1, n, 1);
            else add_event(4'h1, n, 0);
        end
        run_phase("rnd");

        // 6: reset after 2nd payload beat of test 2, then test 1
        rnd_ready = 1'b0;
        rnd_idle = 1'b0;
        set_lens(2, 0, 5, 1);
        add_event(4'h1, 4, 0);
        send_words(7);
        repeat (5) begin @(posedge clk); #1; end
        chk("t6_pending_beats", exp_q.size(), 3);
        exp_q.delete();
        stim_q.delete();
        exp_done--;
        reset_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_outs",
            {bus.s_ready, bus.m_valid, bus.m_data, bus.m_keep, bus.m_idx,
             bus.m_first, bus.m_last},
            0);
        chk("t6_rst_status",
            {evt_fpga_id, evt_nreadouts, evt_done, err_magic, err_version,
             err_length, evt_count, err_count},
            0);
        exp_evt_count = 0;
        exp_err_count = 0;
        last_fid = 8'h00;
        last_n = 4'h0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        set_lens(3, 0, 0, 0);
        add_event(4'h1, 1, 0);
        run_phase("t6");

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
